// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: offers a registered one-hot grant, tracks take/pass/release, drives bus_busy.
// Optional offer timeout is compiled in with `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         busy,
  input  logic [NUM_REQ-1:0]         grant_pass,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       bus_busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       timeout_evt
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OFFER = 2'b01,
    OWNED = 2'b10
  } state_t;

  // Out-of-range parameters leave this empty block elaborated as a visible marker.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 15) begin : g_param_out_of_range
  end

  state_t               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IW-1:0]        owner_q;
  logic [IW-1:0]        ptr_q;
  logic                 bus_busy_q;
  logic                 timeout_evt_q;
`ifdef BUS_ARB_TIMEOUT_EN
  logic [3:0]           cnt_q;
`endif

  logic                 win_valid_d;
  logic [IW-1:0]        win_idx_d;
  logic [NUM_REQ-1:0]   win_onehot_d;

  // Walk from the farthest candidate to the nearest so the one right after ptr wins.
  always_comb begin
    int j;
    j            = 0;
    win_valid_d  = 1'b0;
    win_idx_d    = '0;
    win_onehot_d = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = (int'(ptr_q) + i) % NUM_REQ;
      if (req[j]) begin
        win_valid_d     = 1'b1;
        win_idx_d       = IW'(j);
        win_onehot_d    = '0;
        win_onehot_d[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      ptr_q         <= IW'(NUM_REQ - 1);
      bus_busy_q    <= 1'b0;
      timeout_evt_q <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      timeout_evt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_valid_d) begin
            state_q <= OFFER;
            grant_q <= win_onehot_d;
            owner_q <= win_idx_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        OFFER: begin
          if (busy[owner_q]) begin
            state_q    <= OWNED;
            bus_busy_q <= 1'b1;
          end else if (grant_pass[owner_q]) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= owner_q;
`ifdef BUS_ARB_TIMEOUT_EN
          end else if (cnt_q == 4'(TIMEOUT)) begin
            // Expiry is handled exactly like a pass, plus the event pulse.
            state_q       <= IDLE;
            grant_q       <= '0;
            ptr_q         <= owner_q;
            timeout_evt_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
`endif
          end
        end
        OWNED: begin
          if (!busy[owner_q]) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= owner_q;
            bus_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          grant_q    <= '0;
          bus_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign bus_busy    = bus_busy_q;
  assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: take, round-robin, pass, ignored masters, timeout and async reset.
module tb_bus_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] busy = '0;
  logic [N-1:0] grant_pass = '0;
  logic [N-1:0] grant;
  logic         bus_busy;
  logic [1:0]   owner;
  logic         timeout_evt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_REQ(N), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .busy       (busy),
    .grant_pass (grant_pass),
    .grant      (grant),
    .bus_busy   (bus_busy),
    .owner      (owner),
    .timeout_evt(timeout_evt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; busy = '0; grant_pass = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_oh;
    int         exp_idx;

    // Reset state
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_bus_busy", 32'(bus_busy), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_tevt", 32'(timeout_evt), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Single master take for 3 cycles
    req = 4'b0001;
    @(negedge clk);
    chk("t1_offer_grant", 32'(grant), 32'h1);
    chk("t1_offer_bus_busy", 32'(bus_busy), 32'h0);
    chk("t1_offer_owner", 32'(owner), 32'h0);
    busy = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t1_own_bus_busy", 32'(bus_busy), 32'h1);
      chk("t1_own_grant", 32'(grant), 32'h1);
    end
    busy = '0; req = '0;
    @(negedge clk);
    chk("t1_rel_grant", 32'(grant), 32'h0);
    chk("t1_rel_bus_busy", 32'(bus_busy), 32'h0);
    $display("txn: master 0 held bus 3 cycles and released");

    // Round robin with all masters requesting
    do_reset();
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      exp_idx = r % N;
      exp_oh  = 4'b0001 << exp_idx;
      @(negedge clk);
      chk("rr_grant", 32'(grant), 32'(exp_oh));
      chk("rr_owner", 32'(owner), 32'(exp_idx));
      busy = exp_oh;
      @(negedge clk);
      chk("rr_bus_busy", 32'(bus_busy), 32'h1);
      busy = '0;
      @(negedge clk);
      chk("rr_gap_grant", 32'(grant), 32'h0);
      if (r == 4) req = '0;
      $display("txn: round-robin turn %0d owner %0d", r, exp_idx);
    end

    // Pass from master 0 hands the next offer to master 1
    do_reset();
    req = 4'b0011;
    @(negedge clk);
    chk("pass_first_grant", 32'(grant), 32'h1);
    grant_pass = 4'b0001;
    @(negedge clk);
    chk("pass_gap_grant", 32'(grant), 32'h0);
    grant_pass = '0;
    @(negedge clk);
    chk("pass_next_grant", 32'(grant), 32'h2);
    chk("pass_next_owner", 32'(owner), 32'h1);
    $display("txn: master 0 passed, master 1 offered");

    // busy and grant_pass together: busy wins
    busy = 4'b0010; grant_pass = 4'b0010;
    @(negedge clk);
    chk("both_bus_busy", 32'(bus_busy), 32'h1);
    chk("both_grant", 32'(grant), 32'h2);
    // Non-owner busy/pass and owner grant_pass are ignored in OWNED
    busy = 4'b0110; grant_pass = 4'b0110;
    @(negedge clk);
    chk("ign_grant", 32'(grant), 32'h2);
    chk("ign_bus_busy", 32'(bus_busy), 32'h1);
    chk("ign_owner", 32'(owner), 32'h1);
    $display("txn: master 1 owns bus, others ignored");

    // Asynchronous reset mid-OWNED
    #2 reset = 1'b1;
    #1;
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_bus_busy", 32'(bus_busy), 32'h0);
    @(negedge clk);
    req = 4'b1000; busy = '0; grant_pass = '0; reset = 1'b0;
    @(negedge clk);
    chk("arst_next_grant", 32'(grant), 32'h8);
    chk("arst_next_owner", 32'(owner), 32'h3);
    grant_pass = 4'b1000;
    @(negedge clk);
    grant_pass = '0;
    $display("txn: async reset cleared ownership, master 3 offered after release");

    // Silent master: timeout or indefinite hold
    do_reset();
    req = 4'b0100;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("to_hold_grant", 32'(grant), 32'h4);
      chk("to_hold_evt", 32'(timeout_evt), 32'h0);
    end
    @(negedge clk);
    chk("to_drop_grant", 32'(grant), 32'h0);
    chk("to_drop_evt", 32'(timeout_evt), 32'h1);
    @(negedge clk);
    chk("to_reoffer_grant", 32'(grant), 32'h4);
    chk("to_reoffer_evt", 32'(timeout_evt), 32'h0);
    $display("txn: offer to master 2 timed out and was re-offered");
`else
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("hold_grant", 32'(grant), 32'h4);
      chk("hold_evt", 32'(timeout_evt), 32'h0);
    end
    $display("txn: offer to master 2 held for 100 cycles");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared memory bus used by the icache controller, dcache controller and other bus masters. Each master asks with a level request. The arbiter offers a one-hot registered grant, which the master either takes (asserts busy) or hands back (asserts grant_pass). It drives the global bus_busy seen by all masters, and it replaces the daisy-chained grant/busy wiring with a central sequencer.

## Interface
- NUM_REQ, 4, number of bus masters (2..8); index 0 = icache, 1 = dcache.
- TIMEOUT, 15, offer-timeout cycles (1..15); used only with the timeout feature.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  level request per master
- busy  in  NUM_REQ  master is using the bus; honoured only from the granted master
- grant_pass  in  NUM_REQ  master returns an offered grant unused; honoured only from the granted master
- grant  out  NUM_REQ  registered one-hot grant (all-zero when idle)
- bus_busy  out  1  registered; high while state is OWNED
- owner  out  clog2(NUM_REQ)  index of the granted master; valid when grant is non-zero
- timeout_evt  out  1  one-cycle pulse when an offer times out (always 0 without the macro)

## Operation
- State register, 2 bits:
  - IDLE = 00
  - OFFER = 01
  - OWNED = 10
- Round-robin pointer `ptr` (clog2(NUM_REQ) bits) holds the last owner. The search starts at ptr+1 and wraps modulo NUM_REQ; the first set req bit wins.
- IDLE: grant = 0. If any req is set, load grant/owner with the winner and go to OFFER. Otherwise stay.
- OFFER (master k): grant[k] = 1.
  - busy[k] = 1 → OWNED. busy has priority over grant_pass in the same cycle.
  - Else grant_pass[k] = 1 → ptr <= k, grant <= 0, go to IDLE.
  - Else hold. Dropping req[k] alone does not revoke the grant.
- OWNED (master k): grant[k] = 1, bus_busy = 1.
  - busy[k] = 0 → ptr <= k, grant <= 0, go to IDLE. grant_pass is ignored in OWNED.
- busy, grant_pass and req from non-granted masters never change state.
- Every ownership or pass is followed by at least one IDLE cycle with grant = 0 (bus turnaround).
- Invalid state encoding 11 → IDLE next cycle with grant = 0.
- Reset values:
  - state = IDLE
  - grant = 0
  - owner = 0
  - bus_busy = 0
  - timeout_evt = 0
  - ptr = NUM_REQ-1, so the first search starts at master 0
  - timeout counter = 0

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Request latency: req rises in cycle n while IDLE → grant visible in cycle n+1.
- Take: busy[k] sampled high at edge m while in OFFER → bus_busy high in cycle m+1.
- Release: busy[k] sampled low at edge r while in OWNED → grant and bus_busy are 0 in cycle r+1. The earliest next grant appears in cycle r+2.
- Pass: grant_pass[k] at edge p → grant = 0 in cycle p+1; next offer no earlier than p+2.
- With all masters requesting continuously, each master is offered the bus once every NUM_REQ arbitration rounds.
- Asserting reset mid-transfer clears grant and bus_busy immediately, without waiting for clk. On deassertion the arbiter restarts from IDLE with ptr = NUM_REQ-1.

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - A 4-bit counter clears on entry to OFFER and increments each OFFER cycle with no busy[k] or grant_pass[k].
  - When the counter equals TIMEOUT, the arbiter behaves exactly as a pass: ptr <= k, grant <= 0, go to IDLE. timeout_evt pulses for one cycle, the cycle in which grant drops.
  - busy or grant_pass in the same cycle as expiry wins over the timeout.
- BUS_ARB_TIMEOUT_EN undefined: no counter; an offer is held indefinitely; timeout_evt is tied 0.

## Test plan
- Reset, then req=0001 → grant=0001 one cycle later. Assert busy[0] for 3 cycles: bus_busy high for 3 cycles, then grant=0000 and bus_busy=0.
- req=1111 held; each master takes the bus for 1 cycle in turn → owners appear in order 0,1,2,3,0, with one grant=0000 cycle between owners.
- req=0011, grant to master 0, master 0 asserts grant_pass → grant=0000 next cycle, then grant=0010.
- In OFFER to master 1, assert busy[1] and grant_pass[1] together → OWNED, bus_busy=1. Also: busy[2] asserted while master 1 owns the bus → no effect.
- With BUS_ARB_TIMEOUT_EN and TIMEOUT=4: req=0100 and master 2 stays silent → grant=0100 for 5 cycles, then grant=0000 with timeout_evt=1 for one cycle, then re-offer. Without the macro, the grant is held for 100 cycles.
- Assert reset asynchronously mid-OWNED → grant=0 and bus_busy=0 before the next clk edge. After release with req=1000, the next grant is 1000.
